// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: control FSM for one SHA-256 hash job of 1..MAX_BLOCKS blocks.
// Loads the IV into the H registers at job start, hands in each 512-bit message block,
// steps the round core through ROUNDS rounds, then accumulates H after every block.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, num_blocks job request (sampled in IDLE) and block count (latched on accept)
//   abort             synchronous job cancel, ignored in IDLE
//   msg_valid         block buffer offers the next block
//   msg_ready         block accepted this cycle when msg_valid is also high
//   h_init            one-cycle pulse: H regs load IV
//   round_en          round core advances; round_idx selects K/W
//   h_update          one-cycle pulse: H += working variables
//   block_idx         block in progress
//   busy, done, err   status; done and err are one-cycle pulses
module sha256_block_sequencer #(
  parameter int unsigned ROUNDS     = 64,
  parameter int unsigned RW         = 6,
  parameter int unsigned MAX_BLOCKS = 4,
  parameter int unsigned BW         = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [BW:0]   num_blocks,
  input  logic          abort,
  input  logic          msg_valid,
  output logic          msg_ready,
  output logic          h_init,
  output logic          round_en,
  output logic [RW-1:0] round_idx,
  output logic          h_update,
  output logic [BW-1:0] block_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {StIdle, StLoad, StRounds, StUpdate, StDone} state_e;

  state_e        state_q, state_d;
  logic [BW:0]   count_q, count_d;
  logic [RW-1:0] round_idx_q, round_idx_d;
  logic [BW-1:0] block_idx_q, block_idx_d;
  logic          h_init_q, h_init_d;
  logic          err_q, err_d;
  logic          num_ok;
  logic          last_block;

  assign num_ok     = (num_blocks != '0) && (num_blocks <= (BW + 1)'(MAX_BLOCKS));
  assign last_block = ({1'b0, block_idx_q} == (count_q - (BW + 1)'(1)));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    round_idx_d = round_idx_q;
    block_idx_d = block_idx_q;
    h_init_d    = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_ok) begin
            state_d     = StLoad;
            count_d     = num_blocks;
            block_idx_d = '0;
            h_init_d    = 1'b1;  // high for exactly the first LOAD cycle
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (msg_valid) begin
          state_d     = StRounds;
          round_idx_d = '0;
        end
      end
      StRounds: begin
        if (round_idx_q == RW'(ROUNDS - 1)) begin
          state_d     = StUpdate;
          round_idx_d = '0;
        end else begin
          round_idx_d = round_idx_q + RW'(1);
        end
      end
      StUpdate: begin
        if (last_block) begin
          state_d = StDone;
        end else begin
          state_d     = StLoad;
          block_idx_d = block_idx_q + BW'(1);
        end
      end
      StDone: begin
        state_d     = StIdle;
        block_idx_d = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides every busy-state transition; IDLE keeps its start decision.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      round_idx_d = '0;
      block_idx_d = '0;
      h_init_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      round_idx_q <= '0;
      block_idx_q <= '0;
      h_init_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      round_idx_q <= round_idx_d;
      block_idx_q <= block_idx_d;
      h_init_q    <= h_init_d;
      err_q       <= err_d;
    end
  end

  // Every output is a flop or a decode of the state register.
  assign msg_ready = (state_q == StLoad);
  assign round_en  = (state_q == StRounds);
  assign h_update  = (state_q == StUpdate);
  assign done      = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign h_init    = h_init_q;
  assign err       = err_q;
  assign round_idx = round_idx_q;
  assign block_idx = block_idx_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
module tb_sha256_block_sequencer;

  localparam int NR = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] num_blocks = '0;
  logic       abort = 1'b0;
  logic       msg_valid = 1'b0;
  logic       msg_ready, h_init, round_en, h_update, busy, done, err;
  logic [5:0] round_idx;
  logic [1:0] block_idx;

  int n_checks = 0;
  int n_pass   = 0;

  // Job description consumed by the reference model.
  int job_nb;
  int job_s[4];
  int job_abort;  // cycle in which abort is high, -1 for none

  sha256_block_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_blocks (num_blocks),
    .abort      (abort),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .h_init     (h_init),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .h_update   (h_update),
    .block_idx  (block_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got hang, want finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] obs_vec();
    return {msg_ready, h_init, round_en, round_idx, h_update, block_idx, busy, done, err};
  endfunction

  // Cycle 1 is the first cycle after the edge that samples start. Block b loads from
  // cycle l, stalls s cycles, rounds for NR cycles, then takes one UPDATE cycle.
  function automatic int done_cycle();
    int l = 1;
    for (int b = 0; b < job_nb; b++) l = l + job_s[b] + 1 + NR + 1;
    return l;
  endfunction

  function automatic bit is_xfer(int c);
    int l = 1;
    for (int b = 0; b < job_nb; b++) begin
      if (c == l + job_s[b]) return 1'b1;
      l = l + job_s[b] + 1 + NR + 1;
    end
    return 1'b0;
  endfunction

  function automatic logic [14:0] exp_vec(int c);
    logic       rdy = 0, ini = 0, ren = 0, upd = 0, bsy = 0, dn = 0;
    logic [5:0] ridx = 0;
    logic [1:0] bidx = 0;
    int l = 1;
    int r, u, d;
    d = done_cycle();
    if (job_abort >= 0 && c > job_abort) return '0;
    for (int b = 0; b < job_nb; b++) begin
      r = l + job_s[b] + 1;
      u = r + NR;
      if (c >= l && c <= l + job_s[b]) rdy = 1;
      if (c >= r && c < r + NR) begin
        ren  = 1;
        ridx = 6'(c - r);
      end
      if (c == u) upd = 1;
      if (c >= l && ((b == job_nb - 1) ? (c <= d) : (c <= u))) bidx = 2'(b);
      l = u + 1;
    end
    bsy = (c >= 1 && c <= d);
    ini = (c == 1);
    dn  = (c == d);
    return {rdy, ini, ren, ridx, upd, bidx, bsy, dn, 1'b0};
  endfunction

  // Runs one accepted job from the current negedge, checking every cycle.
  task automatic run_job(input string name, input bit start_abort);
    int d, t, lim;
    logic [14:0] e, o;
    d   = done_cycle();
    t   = (job_abort >= 0) ? job_abort + 2 : d + 2;
    lim = (job_abort >= 0 && job_abort < d) ? job_abort : d;
    start      = 1'b1;
    num_blocks = 3'(job_nb);
    abort      = start_abort;
    msg_valid  = 1'b0;
    for (int c = 1; c <= t; c++) begin
      @(posedge clk);
      #1;
      e          = exp_vec(c);
      start      = (c <= lim) ? 1'($urandom_range(0, 1)) : 1'b0;
      num_blocks = 3'($urandom_range(0, 7));
      abort      = (c == job_abort);
      msg_valid  = is_xfer(c) || (e[12] && 1'($urandom_range(0, 1)));
      @(negedge clk);
      o = obs_vec();
      n_checks++;
      if (o !== e) $display("FAIL %s cycle %0d: got %b want %b", name, c, o, e);
      else n_pass++;
    end
    start = 1'b0; abort = 1'b0; msg_valid = 1'b0;
  endtask

  task automatic set_job(input int nb, input int s0, input int s1, input int s2, input int s3,
                         input int ab);
    job_nb = nb;
    job_s[0] = s0; job_s[1] = s1; job_s[2] = s2; job_s[3] = s3;
    job_abort = ab;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (obs_vec() !== '0) $display("FAIL reset_held: got %b want 0", obs_vec());
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== '0) $display("FAIL reset_released: got %b want 0", obs_vec());
    else n_pass++;
  endtask

  task automatic test_single();
    set_job(1, 0, 0, 0, 0, -1);
    run_job("single", 1'b0);
  endtask

  task automatic test_two_block();
    set_job(2, 0, 0, 0, 0, -1);
    run_job("two_block", 1'b0);
  endtask

  task automatic test_stall();
    set_job(2, 0, 10, 0, 0, -1);
    n_checks++;
    if (done_cycle() != 143) $display("FAIL stall_model_done: got %0d want 143", done_cycle());
    else n_pass++;
    run_job("stall", 1'b0);
  endtask

  task automatic test_err();
    int vals[4] = '{0, 5, 6, 7};
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      num_blocks = 3'(vals[i]);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== 15'b1) $display("FAIL err_pulse nb=%0d: got %b want %b", vals[i],
                                        obs_vec(), 15'b1);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== '0) $display("FAIL err_clear nb=%0d: got %b want 0", vals[i], obs_vec());
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    set_job(1, 0, 0, 0, 0, 32);  // round_idx 30 of block 0 is cycle 32
    run_job("abort", 1'b0);
    set_job(1, 0, 0, 0, 0, -1);
    run_job("after_abort", 1'b0);
  endtask

  task automatic test_start_abort_idle();
    set_job(1, 0, 0, 0, 0, -1);
    run_job("start_abort_idle", 1'b1);
  endtask

  task automatic test_async_reset();
    start = 1'b1; num_blocks = 3'd3; msg_valid = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    n_checks++;
    if (round_en !== 1'b1) $display("FAIL async_pre_round_en: got %b want 1", round_en);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_vec() !== '0) $display("FAIL async_reset: got %b want 0", obs_vec());
    else n_pass++;
    msg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_job(2, 1, 2, 0, 0, -1);
    run_job("after_async_reset", 1'b0);
  endtask

  task automatic test_random();
    int nb, d;
    for (int j = 0; j < 8; j++) begin
      nb = $urandom_range(1, 4);
      set_job(nb, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), -1);
      d = done_cycle();
      if ($urandom_range(0, 2) == 0) job_abort = $urandom_range(1, d - 1);
      run_job("random", 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_block();
    test_stall();
    test_err();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
